// File: rtl/wb_arbiter.sv
// Write-back arbiter: sole driver of the register-file write port. The pipeline
// write-back has strict priority; long-latency results queue in a FIFO and drain into idle cycles.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     pri_wen,
  input  logic [4:0]               pri_wsel,
  input  logic [31:0]              pri_wdat,
  input  logic                     sec_valid,
  output logic                     sec_ready,
  input  logic [4:0]               sec_wsel,
  input  logic [31:0]              sec_wdat,
  output logic                     WEN,
  output logic [4:0]               wsel,
  output logic [31:0]              wdat,
  input  logic [4:0]               chk_sel,
  output logic                     chk_pending,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    fsel_q [DEPTH];
  logic [31:0]   fdat_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          wen_q, wen_d;
  logic [4:0]    wsel_q, wsel_d;
  logic [31:0]   wdat_q, wdat_d;
  logic          pri_go, push, pop, nempty, hit;
  logic [AW-1:0] idx;

  // Writes to r0 are architecturally void, so they neither queue nor occupy the port.
  assign nempty    = (count_q != '0);
  assign sec_ready = (count_q != CW'(DEPTH));
  assign pri_go    = pri_wen && (pri_wsel != 5'd0);
  assign push      = sec_valid && sec_ready && (sec_wsel != 5'd0);
  assign pop       = !pri_go && nempty;

  always_comb begin
    wen_d  = 1'b0;
    wsel_d = wsel_q;
    wdat_d = wdat_q;
    if (pri_go) begin
      wen_d  = 1'b1;
      wsel_d = pri_wsel;
      wdat_d = pri_wdat;
    end else if (nempty) begin
      wen_d  = 1'b1;
      wsel_d = fsel_q[rd_ptr_q];
      wdat_d = fdat_q[rd_ptr_q];
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wen_q    <= 1'b0;
      wsel_q   <= '0;
      wdat_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fsel_q[i] <= '0;
        fdat_q[i] <= '0;
      end
    end else begin
      wen_q   <= wen_d;
      wsel_q  <= wsel_d;
      wdat_q  <= wdat_d;
      count_q <= count_d;
      if (push) begin
        fsel_q[wr_ptr_q] <= sec_wsel;
        fdat_q[wr_ptr_q] <= sec_wdat;
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Scan only the live window [rd_ptr, rd_ptr+count) so stale slots never alias.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + AW'(i);
      if ((CW'(i) < count_q) && (fsel_q[idx] == chk_sel)) hit = 1'b1;
    end
  end

  assign chk_pending = (chk_sel != 5'd0) && (hit || (wen_q && (wsel_q == chk_sel)));
  assign WEN         = wen_q;
  assign wsel        = wsel_q;
  assign wdat        = wdat_q;
  assign fifo_count  = count_q;
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter placed directly upstream of the register file, and the sole driver of its single write port (WEN, wsel, wdat). It merges two result sources: the in-order pipeline write-back, which has strict priority and is never stalled, and a long-latency unit (multiplier/divider, late load returns) that hands results over through a valid/ready handshake. Secondary results wait in a small FIFO and drain into idle write-port cycles. A combinational pending-write query lets the hazard unit stall readers of registers whose writes are still queued.

## Interface
- DEPTH, 4: secondary FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on posedge.
- n_rst  in  1  asynchronous, active-low reset.
- pri_wen  in  1  pipeline write-back request this cycle.
- pri_wsel  in  5  pipeline destination register.
- pri_wdat  in  32  pipeline write data.
- sec_valid  in  1  long-latency result offered.
- sec_ready  out  1  FIFO can accept; equals !full.
- sec_wsel  in  5  secondary destination register.
- sec_wdat  in  32  secondary write data.
- WEN  out  1  register-file write enable (registered).
- wsel  out  5  register-file write select (registered).
- wdat  out  32  register-file write data (registered).
- chk_sel  in  5  register index queried by the hazard unit.
- chk_pending  out  1  a write to chk_sel is still outstanding.
- fifo_count  out  $clog2(DEPTH)+1  valid FIFO entries.

## Operation
- Reset (n_rst low, asynchronous): WEN=0, wsel=0, wdat=0, FIFO empty, fifo_count=0, read/write pointers 0. sec_ready=1, since it follows the empty state. No writes are issued.
- Secondary accept: at a posedge where sec_valid && sec_ready.
  - sec_wsel≠0: push {sec_wsel, sec_wdat} at the tail.
  - sec_wsel=0: the handshake completes, nothing is pushed, and count is unchanged.
- sec_ready = (fifo_count != DEPTH). It is not relaxed when a pop occurs in the same cycle.
- Output-register load at each posedge, in priority order:
  1. pri_wen && pri_wsel≠0: load WEN=1, wsel/wdat from the primary inputs. The FIFO does not pop.
  2. Otherwise, FIFO non-empty: pop the head and load WEN=1, wsel/wdat from the head.
  3. Otherwise: WEN=0. wsel/wdat hold their previous values.
- A primary request to register 0 counts as idle. The FIFO may drain in that cycle.
- Push and pop may occur on the same posedge. Count is then unchanged and the pointers both advance, wrapping modulo DEPTH.
- FIFO order is strictly first-in first-out. There is no squashing or merging of entries with equal wsel.
- chk_pending (combinational) = chk_sel≠0 && (any valid FIFO entry has wsel==chk_sel, or (WEN && wsel==chk_sel)).
- Same-register ordering between the primary and secondary sources is not resolved here. The hazard unit must stall on chk_pending.

## Timing
- Primary latency: request in cycle t produces WEN/wsel/wdat in cycle t+1. The register file captures on the falling edge within t+1.
- Secondary latency, empty FIFO, no primary traffic: accepted at edge e0, popped at e1, WEN high during the cycle after e1 (2 cycles minimum).
- Starvation: a continuous primary stream blocks draining indefinitely. Once the FIFO is full, sec_ready stays 0; this is permitted.
- Reset mid-operation: queued entries and any in-flight output write are discarded. WEN drops immediately and asynchronously.
- fifo_count and sec_ready are derived from registered state only and never depend combinationally on sec_valid.

## Test plan
- Reset, then pri_wen=1, pri_wsel=5, pri_wdat=0xDEADBEEF for one cycle -> next cycle WEN=1, wsel=5, wdat=0xDEADBEEF; the cycle after, WEN=0.
- Secondary push wsel=7, wdat=0x11 with pri_wen=0 -> chk_sel=7 gives chk_pending=1 while the entry is queued and while it is on the outputs; WEN=1/wsel=7 two cycles after accept; chk_pending=0 afterwards.
- Hold pri_wen=1 (wsel=3) and push 4 secondaries wsel=8..11 -> fifo_count=4, sec_ready=0. Drop pri_wen -> outputs wsel 8, 9, 10, 11 on consecutive cycles; sec_ready=1 after the first pop.
- FIFO at count 3: push and pop on the same edge -> count stays 3. Run 10 push/pop pairs -> pointers wrap and data order is preserved.
- Primary write to wsel=0 while FIFO holds wsel=4 -> the drain proceeds, outputs WEN=1, wsel=4. Secondary push with wsel=0 -> accepted, count unchanged, chk_sel=0 gives chk_pending=0.
- Assert n_rst low with 2 entries queued and WEN=1 -> WEN=0, count=0, sec_ready=1 immediately. After release, no stale writes appear.
